// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT memory controller slice.
// STG_W is sized from FFT_N, the largest transform this build supports
// (stage index 0..FFT_N-1); smaller N instances reuse the same width.
package fft_pkg;

  localparam int unsigned FFT_N = 9;
  localparam int unsigned STG_W = $clog2(FFT_N);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_UNLOAD
  } fft_ctrl_state_t;

  // Reverse the low n bits of v; bits above n come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned n);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < n; i++) begin
      r[i] = v[n-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_agu.sv
// Butterfly address generator: operand address and twiddle index for
// butterfly j of stage s. Purely combinational.
module fft_agu
  import fft_pkg::*;
#(
  parameter int unsigned N = 9
) (
  input  logic [STG_W-1:0] s_i,
  input  logic [N-2:0]     j_i,
  input  logic             phase_i,
  output logic [N-1:0]     addr_o,
  output logic [N-2:0]     tw_add_o
);

  logic [N-1:0] span;
  logic [N-1:0] pos;
  logic [N-1:0] a;

  // span = 2^s; a keeps the low s bits of j and opens a zero at bit s.
  always_comb begin
    span     = N'(1) << s_i;
    pos      = {1'b0, j_i} & (span - N'(1));
    a        = (({1'b0, j_i} >> s_i) << (s_i + STG_W'(1))) | pos;
    addr_o   = phase_i ? (a | span) : a;
    tw_add_o = pos[N-2:0] << (STG_W'(N - 1) - s_i);
  end

endmodule

// File: rtl/fft_mem_ctrl.sv
// Ping-pong RAM sequencer for one radix-2 DIT FFT frame:
// bit-reversed load -> N butterfly stages -> natural-order unload.
// Optional build macro FFT_CTRL_CYCCNT_EN adds the cyc_count output.
module fft_mem_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned N        = 9,
  parameter int unsigned BFLY_LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         unload_valid,
  input  logic         unload_ready,
  output logic         busy,
  output logic         done,
  output logic         ram0_we,
  output logic [N-1:0] ram0_add,
  output logic         ram1_we,
  output logic [N-1:0] ram1_add,
  output logic         wsel,
  output logic         rd_bank,
  output logic         op_a_en,
  output logic         op_b_en,
  output logic         res_sel,
  output logic [N-2:0] tw_add
`ifdef FFT_CTRL_CYCCNT_EN
  ,
  output logic [31:0]  cyc_count
`endif
);

  localparam int unsigned DL = BFLY_LAT + 1;
  localparam int unsigned DW = $clog2(DL + 1);
  localparam logic [N-1:0]     CNT_LAST   = '1;
  localparam logic [N-2:0]     J_LAST     = '1;
  localparam logic [STG_W-1:0] S_LAST     = STG_W'(N - 1);
  localparam logic [DW-1:0]    DR_LAST    = DW'(BFLY_LAT);
  localparam logic             FINAL_BANK = 1'(N % 2);

  typedef struct packed {
    logic         vld;
    logic [N-1:0] addr;
    logic         ph;
  } wr_slot_t;

  fft_ctrl_state_t  state_q, state_d;
  logic [N-1:0]     cnt_q, cnt_d;
  logic [STG_W-1:0] s_q, s_d;
  logic [N-2:0]     j_q, j_d;
  logic             ph_q, ph_d;
  logic [DW-1:0]    dr_q, dr_d;
  logic             done_q, done_d;
  wr_slot_t         dl_q [DL];
  wr_slot_t         push, wr;
  logic [N-1:0]     rd_addr;
  logic [N-2:0]     agu_tw;

  fft_agu #(.N(N)) u_agu (
    .s_i      (s_q),
    .j_i      (j_q),
    .phase_i  (ph_q),
    .addr_o   (rd_addr),
    .tw_add_o (agu_tw)
  );

  // State, counters and done pulse register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      j_q     <= '0;
      ph_q    <= 1'b0;
      dr_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      j_q     <= j_d;
      ph_q    <= ph_d;
      dr_q    <= dr_d;
      done_q  <= done_d;
    end
  end

  // Write delay line: a read issued in cycle t is written back in cycle t+DL.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DL; i++) dl_q[i] <= '0;
    end else begin
      dl_q[0] <= push;
      for (int unsigned i = 1; i < DL; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    j_d     = j_q;
    ph_d    = ph_q;
    dr_d    = dr_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          cnt_d = cnt_q + N'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            s_d     = '0;
            j_d     = '0;
            ph_d    = 1'b0;
          end
        end
      end
      ST_RUN: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          j_d = j_q + (N-1)'(1);
          if (j_q == J_LAST) begin
            state_d = ST_DRAIN;
            dr_d    = '0;
          end
        end
      end
      ST_DRAIN: begin
        dr_d = dr_q + DW'(1);
        if (dr_q == DR_LAST) begin
          if (s_q == S_LAST) begin
            state_d = ST_UNLOAD;
            cnt_d   = '0;
          end else begin
            state_d = ST_RUN;
            s_d     = s_q + STG_W'(1);
            j_d     = '0;
            ph_d    = 1'b0;
          end
        end
      end
      ST_UNLOAD: begin
        if (unload_ready) begin
          cnt_d = cnt_q + N'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: reads go to bank s[0], delayed writes to the other bank.
  always_comb begin
    load_ready   = 1'b0;
    unload_valid = 1'b0;
    ram0_we      = 1'b0;
    ram0_add     = '0;
    ram1_we      = 1'b0;
    ram1_add     = '0;
    wsel         = 1'b0;
    rd_bank      = 1'b0;
    op_a_en      = 1'b0;
    op_b_en      = 1'b0;
    res_sel      = 1'b0;
    tw_add       = '0;
    push         = '0;
    wr           = dl_q[DL-1];
    case (state_q)
      ST_LOAD: begin
        load_ready = 1'b1;
        ram0_we    = load_valid;
        ram0_add   = N'(bitrev(32'(cnt_q), N));
      end
      ST_RUN: begin
        wsel    = 1'b1;
        rd_bank = s_q[0];
        op_a_en = ~ph_q;
        op_b_en = ph_q;
        tw_add  = agu_tw;
        push    = '{vld: 1'b1, addr: rd_addr, ph: ph_q};
        if (s_q[0]) ram1_add = rd_addr;
        else        ram0_add = rd_addr;
      end
      ST_DRAIN: begin
        wsel    = 1'b1;
        rd_bank = s_q[0];
      end
      ST_UNLOAD: begin
        unload_valid = 1'b1;
        rd_bank      = FINAL_BANK;
        if (FINAL_BANK) ram1_add = cnt_q;
        else            ram0_add = cnt_q;
      end
      default: ;
    endcase
    if (wr.vld) begin
      res_sel = wr.ph;
      if (s_q[0]) begin
        ram0_we  = 1'b1;
        ram0_add = wr.addr;
      end else begin
        ram1_we  = 1'b1;
        ram1_add = wr.addr;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

`ifdef FFT_CTRL_CYCCNT_EN
  logic [31:0] cyc_cnt_q;
  logic [31:0] cyc_count_q;

  // Frame cycle counter; snapshot taken on the edge that raises done.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt_q   <= '0;
      cyc_count_q <= '0;
    end else begin
      if (state_q == ST_IDLE && start) cyc_cnt_q <= '0;
      else if (state_q != ST_IDLE)     cyc_cnt_q <= cyc_cnt_q + 32'd1;
      if (done_d) cyc_count_q <= cyc_cnt_q + 32'd1;
    end
  end

  assign cyc_count = cyc_count_q;
`endif

endmodule

// File: tb/tb_fft_mem_ctrl.sv
// Self-checking bench for fft_mem_ctrl (N=3, BFLY_LAT=2) with behavioural
// RAM banks, an add/sub butterfly and a reference transform.
module tb_fft_mem_ctrl;

  localparam int unsigned N        = 3;
  localparam int unsigned BFLY_LAT = 2;
  localparam int unsigned LEN      = 1 << N;
  localparam int unsigned HALF     = LEN / 2;
  localparam int unsigned DLY      = BFLY_LAT + 1;
  localparam int unsigned STAGE_CYC = LEN + BFLY_LAT + 1;

  logic         clk = 1'b0;
  logic         reset, start, load_valid, unload_ready;
  logic         load_ready, unload_valid, busy, done;
  logic         ram0_we, ram1_we, wsel, rd_bank, op_a_en, op_b_en, res_sel;
  logic [N-1:0] ram0_add, ram1_add;
  logic [N-2:0] tw_add;
`ifdef FFT_CTRL_CYCCNT_EN
  logic [31:0]  cyc_count;
  int unsigned  busy_cnt = 0;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fft_mem_ctrl #(.N(N), .BFLY_LAT(BFLY_LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .unload_valid (unload_valid),
    .unload_ready (unload_ready),
    .busy         (busy),
    .done         (done),
    .ram0_we      (ram0_we),
    .ram0_add     (ram0_add),
    .ram1_we      (ram1_we),
    .ram1_add     (ram1_add),
    .wsel         (wsel),
    .rd_bank      (rd_bank),
    .op_a_en      (op_a_en),
    .op_b_en      (op_b_en),
    .res_sel      (res_sel),
    .tw_add       (tw_add)
`ifdef FFT_CTRL_CYCCNT_EN
    ,
    .cyc_count    (cyc_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural data path around the controller.
  logic [15:0] mem0 [LEN];
  logic [15:0] mem1 [LEN];
  logic [15:0] load_data, opa, dout, din;
  logic [31:0] bpipe [BFLY_LAT];
  logic [31:0] outs;

  assign dout = rd_bank ? mem1[ram1_add] : mem0[ram0_add];
  assign din  = !wsel ? load_data :
                (res_sel ? bpipe[BFLY_LAT-1][15:0] : bpipe[BFLY_LAT-1][31:16]);
  assign outs = 32'({load_ready, unload_valid, busy, done, ram0_we, ram0_add,
                     ram1_we, ram1_add, wsel, rd_bank, op_a_en, op_b_en, res_sel, tw_add});

  always @(posedge clk) begin
    if (ram0_we) mem0[ram0_add] <= din;
    if (ram1_we) mem1[ram1_add] <= din;
    if (op_a_en) opa <= dout;
    if (op_b_en) bpipe[0] <= {opa + dout, opa - dout};
    for (int i = 1; i < BFLY_LAT; i++) bpipe[i] <= bpipe[i-1];
  end

`ifdef FFT_CTRL_CYCCNT_EN
  always @(posedge clk) begin
    if (!busy && start) busy_cnt <= 0;
    else if (busy)      busy_cnt <= busy_cnt + 1;
  end
`endif

  // A bank being read must never be written in the same cycle.
  always @(negedge clk) begin
    #2;
    if (op_a_en || op_b_en || unload_valid)
      check_eq("bank_sep", rd_bank ? ram1_we : ram0_we, 0);
  end

  // Reference addressing and transform.
  int unsigned pa [N][HALF];
  int unsigned pb [N][HALF];
  int unsigned ptw [N][HALF];
  logic [15:0] y [LEN];

  function automatic int unsigned rev(input int unsigned v);
    int unsigned r = 0;
    for (int i = 0; i < N; i++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  task automatic build_pairs();
    for (int s = 0; s < N; s++) begin
      int unsigned span = 1 << s;
      int unsigned idx = 0;
      for (int unsigned blk = 0; blk < LEN; blk += 2 * span) begin
        for (int unsigned k = 0; k < span; k++) begin
          pa[s][idx]  = blk + k;
          pb[s][idx]  = blk + k + span;
          ptw[s][idx] = k * (LEN / (2 * span));
          idx++;
        end
      end
    end
  endtask

  task automatic build_ref(input logic [15:0] x [LEN]);
    logic [15:0] t;
    for (int i = 0; i < LEN; i++) y[rev(i)] = x[i];
    for (int s = 0; s < N; s++) begin
      for (int j = 0; j < HALF; j++) begin
        t = y[pa[s][j]];
        y[pa[s][j]] = t + y[pb[s][j]];
        y[pb[s][j]] = t - y[pb[s][j]];
      end
    end
  endtask

  task automatic run_frame(input int fr, input bit abort);
    logic [15:0] x [LEN];
    int beats = 0;
    int guard = 0;
    int k = 0;
    int hold = 0;
    bit lvb;
    int rdb, ph, w;
    @(negedge clk);
    start = 1'b1;
    #1 check_eq("idle_busy", busy, 0);
    @(negedge clk);
    start = 1'b0;
    while (beats < LEN && guard < 64) begin
      lvb = (fr == 0) ? (guard % 2 == 0) : 1'($urandom % 2);
      load_valid = lvb;
      load_data  = 16'($urandom);
      #1;
      check_eq("ld_ready", load_ready, 1);
      check_eq("ld_busy", busy, 1);
      check_eq("ld_we", ram0_we, lvb);
      if (lvb) begin
        check_eq("ld_addr", ram0_add, rev(beats));
        x[beats] = load_data;
        beats++;
      end
      guard++;
      @(negedge clk);
    end
    load_valid = 1'b0;
    check_eq("ld_beats", beats, LEN);
    build_ref(x);
    for (int s = 0; s < N; s++) begin
      for (int c = 0; c < STAGE_CYC; c++) begin
        if (abort && s == 1 && c == 4) begin
          reset = 1'b1;
          repeat (3) begin
            @(negedge clk);
            #1 check_eq("rst_outs", outs, 0);
          end
          reset = 1'b0;
          @(negedge clk);
          #1 check_eq("post_rst_outs", outs, 0);
          return;
        end
        start = (fr == 0 && s == 1 && c == 2);
        #1;
        rdb = s % 2;
        check_eq("run_rdbank", rd_bank, rdb);
        check_eq("run_wsel", wsel, 1);
        check_eq("run_busy", busy, 1);
        if (c < LEN) begin
          ph = c % 2;
          check_eq("op_a_en", op_a_en, ph == 0);
          check_eq("op_b_en", op_b_en, ph == 1);
          check_eq("rd_addr", rdb ? ram1_add : ram0_add, ph ? pb[s][c/2] : pa[s][c/2]);
          if (ph == 1) check_eq("tw_add", tw_add, ptw[s][c/2]);
        end else begin
          check_eq("drain_noread", op_a_en | op_b_en, 0);
        end
        if (c >= DLY && c < LEN + DLY) begin
          w = c - DLY;
          check_eq("wr_we", rdb ? ram0_we : ram1_we, 1);
          check_eq("wr_addr", rdb ? ram0_add : ram1_add, (w % 2) ? pb[s][w/2] : pa[s][w/2]);
          check_eq("wr_ressel", res_sel, w % 2);
        end else begin
          check_eq("wr_idle", rdb ? ram0_we : ram1_we, 0);
        end
        @(negedge clk);
        start = 1'b0;
      end
    end
    guard = 0;
    while (k < LEN && guard < 64) begin
      if (k == 3 && hold < 5) begin
        unload_ready = 1'b0;
        hold++;
      end else begin
        unload_ready = ($urandom % 4) != 0;
      end
      #1;
      check_eq("ul_valid", unload_valid, 1);
      check_eq("ul_bank", rd_bank, N % 2);
      check_eq("ul_addr", ram1_add, k);
      check_eq("ul_data", dout, y[k]);
      check_eq("ul_nowe", ram0_we | ram1_we, 0);
      check_eq("ul_nodone", done, 0);
      if (unload_ready) k++;
      guard++;
      @(negedge clk);
    end
    unload_ready = 1'b0;
    check_eq("ul_beats", k, LEN);
    #1;
    check_eq("done_pulse", done, 1);
    check_eq("done_idle", busy, 0);
`ifdef FFT_CTRL_CYCCNT_EN
    check_eq("cyc_count", cyc_count, busy_cnt);
`endif
    @(negedge clk);
    #1 check_eq("done_clear", done, 0);
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    load_valid   = 1'b0;
    unload_ready = 1'b0;
    load_data    = '0;
    build_pairs();
    repeat (3) @(negedge clk);
    #1 check_eq("reset_outs", outs, 0);
    @(negedge clk);
    reset = 1'b0;
    run_frame(0, 1'b0);
    run_frame(1, 1'b1);
    run_frame(2, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/fft_mem_ctrl.md
Name: fft_mem_ctrl

Overview:
- Sequences the two single-port sample RAM banks (bank0/bank1, 2^N words each, combinational read, write on posedge when we) through one radix-2 DIT FFT frame.
- Frame phases: bit-reversed load → N ping-pong butterfly stages → natural-order unload.
- Drives RAM addresses and write enables, data-path muxes, butterfly operand strobes and the twiddle ROM address.
- Sits between the sample input stream, the butterfly unit and the spectrum output stream.

Parameters:
N, 9, log2 of FFT length; also the RAM address width.
BFLY_LAT, 2, cycles from op_b_en to the butterfly result pair being valid; must be ≥1.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  frame start pulse; sampled in IDLE only
load_valid  in  1  input sample present
load_ready  out  1  controller accepts a sample
unload_valid  out  1  output word available on selected bank dout
unload_ready  in  1  consumer accepts the output word
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the last unload beat
ram0_we  out  1  bank0 write enable
ram0_add  out  N  bank0 address
ram1_we  out  1  bank1 write enable
ram1_add  out  N  bank1 address
wsel  out  1  write-data mux: 0 = input sample, 1 = butterfly result
rd_bank  out  1  dout mux into butterfly/unload: 0 = bank0, 1 = bank1
op_a_en  out  1  butterfly captures operand A from selected dout
op_b_en  out  1  butterfly captures operand B
res_sel  out  1  write-data result mux: 0 = result A, 1 = result B
tw_add  out  N-1  twiddle ROM address

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: state IDLE; all counters 0; every output 0; write delay line cleared. Reset mid-frame aborts the frame, and no RAM write occurs in any cycle after reset is sampled.
- FSM states: IDLE, LOAD, RUN, DRAIN, UNLOAD. Outputs are registered or decoded from registers only, never from load_valid/unload_ready except where noted.
- IDLE:
  - start → LOAD; busy rises the next cycle.
  - start outside IDLE is ignored.
- LOAD:
  - load_ready=1, wsel=0.
  - Beat = load_valid&&load_ready.
  - ram0_we=load_valid, ram0_add=bitrev(cnt). This is the only combinational path from load_valid.
  - cnt advances on each beat; no beat means hold.
  - Beat at cnt=2^N-1 → RUN with stage=0, j=0.
- RUN (stage s, butterfly j = 0..2^(N-1)-1, two cycles per butterfly):
  - Read bank = s[0]; write bank = ~s[0]; rd_bank=s[0]; wsel=1.
  - span=1<<s, pos=j&(span-1), a=((j>>s)<<(s+1))|pos, b=a|span, tw_add=pos<<(N-1-s).
  - Phase 0: read-bank addr=a, op_a_en=1. Phase 1: addr=b, op_b_en=1, tw_add valid.
  - Each read cycle pushes {addr, phase} into a BFLY_LAT+1 deep delay line.
  - Delay-line output drives: write-bank we=1, write-bank add=delayed addr, res_sel=delayed phase.
  - After phase 1 of the last j → DRAIN.
- DRAIN:
  - Reads stop; the delay line empties over BFLY_LAT+1 cycles.
  - Then, if s<N-1: s++, j=0 → RUN. Otherwise → UNLOAD.
  - Cycles per stage = 2^N + BFLY_LAT + 1.
- UNLOAD:
  - rd_bank=N[0] (final bank); final-bank add=cnt; unload_valid=1.
  - Beat on unload_ready advances cnt.
  - Beat at cnt=2^N-1: done=1 for one cycle, then IDLE.
  - No writes occur in UNLOAD.
- Bank separation: read and write in the same cycle always target different banks. A bank's we is never asserted while the same bank is being read.

Optional Feature:
- Macro: FFT_CTRL_CYCCNT_EN.
- Defined:
  - Adds output port cyc_count[31:0].
  - Internal counter clears on start accepted and increments each cycle while busy.
  - cyc_count latches the counter value on done and holds it until the next done.
  - Reset value 0.
- Undefined: no port, no counter logic.

Decomposition:
- Shared package fft_pkg:
  - state enum fft_ctrl_state_t.
  - function bitrev(N-bit).
  - localparam STG_W=$clog2(N).
- One sub-module, fft_agu:
  - Inputs: s, j, phase. Outputs: a/b select address and tw_add.
  - Purely combinational.
- Counters, FSM and write delay line stay in fft_mem_ctrl.

Test Plan:
- Reset/idle: N=3, reset held 3 cycles mid-RUN → all outputs 0 next cycle; no we; start ignored until IDLE is reached.
- Load order: N=3, 8 beats with load_valid toggled 1/0 → ram0_add sequence 0,4,2,6,1,5,3,7; ram0_we only on valid cycles.
- Stage addressing: N=3, BFLY_LAT=2:
  - s=0 read addr pairs (0,1),(2,3),(4,5),(6,7), tw 0.
  - s=1 pairs (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2.
  - s=2 pairs (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3.
  - Each stage lasts 11 cycles.
- Write timing: first write of s=0 on bank1, addr 0, res_sel=0, exactly 3 cycles after the first op_a_en.
- Ping-pong check: every cycle asserts no same-bank read+write; reads at s=0,1,2 come from banks 0,1,0; unload reads bank1.
- Unload backpressure: unload_ready low 5 cycles at cnt=3 → addr holds 3; after 8 beats done pulses once; with FFT_CTRL_CYCCNT_EN, cyc_count = cycles from start to done.
